// File: rtl/fetch_unit.sv
// Fetch PC sequencer: reset, sequential fetch, stall, redirect, halt.
// Interrupt vectoring, EPC capture and int_ack exist only when FETCH_INTERRUPT_EN is defined.
`ifndef PC_SIZE
`define PC_SIZE 8
`endif

module fetch_unit #(
   parameter logic [`PC_SIZE-1:0] RESET_PC        = '0,
   parameter logic [`PC_SIZE-1:0] INT_VECTOR_BASE = `PC_SIZE'('h10)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_halt,
   input  logic                i_stall,
   input  logic                i_pc_override,
   input  logic [`PC_SIZE-1:0] i_target,
   input  logic                i_interrupt,
   input  logic [3:0]          i_int_code,
   output logic [`PC_SIZE-1:0] o_pc,
   output logic                o_valid,
   output logic                o_halted,
   output logic [`PC_SIZE-1:0] o_epc,
   output logic                o_int_ack
);

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [`PC_SIZE-1:0] pc_q, pc_d;
   logic [`PC_SIZE-1:0] epc_q, epc_d;
   logic                int_ack_q, int_ack_d;
   logic                int_take;

`ifdef FETCH_INTERRUPT_EN
   assign int_take = i_interrupt;
`else
   // Interrupt inputs are deliberately ignored; fold them into a sink net.
   logic unused_int;
   assign int_take   = 1'b0;
   assign unused_int = ^{i_interrupt, i_int_code};
`endif

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      epc_d     = epc_q;
      int_ack_d = 1'b0;
      if (int_take) begin
         // Interrupt wins in either state, and is the only way out of HALTED.
         pc_d      = INT_VECTOR_BASE + `PC_SIZE'(i_int_code);
         epc_d     = pc_q;
         state_d   = RUN;
         int_ack_d = 1'b1;
      end else if (state_q == RUN) begin
         if (i_halt) begin
            state_d = HALTED;
         end else if (i_pc_override) begin
            pc_d = i_target;
         end else if (!i_stall) begin
            pc_d = pc_q + `PC_SIZE'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= RUN;
         pc_q      <= RESET_PC;
         epc_q     <= '0;
         int_ack_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         epc_q     <= epc_d;
         int_ack_q <= int_ack_d;
      end
   end

   assign o_pc      = pc_q;
   assign o_halted  = (state_q == HALTED);
   assign o_epc     = epc_q;
   assign o_int_ack = int_ack_q;
   assign o_valid   = (state_q == RUN) & ~i_stall & ~i_pc_override & ~i_halt & ~int_take;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus tables push expected post-edge state,
// popped and compared after each rising edge; interrupt tests follow FETCH_INTERRUPT_EN.
`ifndef PC_SIZE
`define PC_SIZE 8
`endif

module tb_fetch_unit;
   localparam int PW = `PC_SIZE;

   typedef struct {
      logic          st, ov, hl, it;
      logic [PW-1:0] tg;
      logic [3:0]    code;
      logic          ev;
      logic [PW-1:0] pc;
      logic          halted;
      logic [PW-1:0] epc;
      logic          ack;
   } step_t;

   typedef struct {
      logic [PW-1:0] pc;
      logic          halted;
      logic [PW-1:0] epc;
      logic          ack;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_halt = 1'b0, i_stall = 1'b0, i_pc_override = 1'b0, i_interrupt = 1'b0;
   logic [PW-1:0] i_target = '0;
   logic [3:0]    i_int_code = '0;
   logic [PW-1:0] o_pc, o_epc;
   logic          o_valid, o_halted, o_int_ack;

   exp_t sb[$];
   int   passed = 0;
   int   total  = 0;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC('0), .INT_VECTOR_BASE(PW'('h10))) dut (
      .clk(clk), .rst(rst), .i_halt(i_halt), .i_stall(i_stall),
      .i_pc_override(i_pc_override), .i_target(i_target),
      .i_interrupt(i_interrupt), .i_int_code(i_int_code),
      .o_pc(o_pc), .o_valid(o_valid), .o_halted(o_halted),
      .o_epc(o_epc), .o_int_ack(o_int_ack)
   );

`ifdef FETCH_INTERRUPT_EN
   logic          w_halt = 1'b0, w_interrupt = 1'b0;
   logic [3:0]    w_int_code = '0;
   logic [PW-1:0] w_pc, w_epc;
   logic          w_valid, w_halted, w_int_ack;

   fetch_unit #(.RESET_PC('0), .INT_VECTOR_BASE({PW{1'b1}} - PW'(1))) dut_wrap (
      .clk(clk), .rst(rst), .i_halt(w_halt), .i_stall(1'b0),
      .i_pc_override(1'b0), .i_target('0),
      .i_interrupt(w_interrupt), .i_int_code(w_int_code),
      .o_pc(w_pc), .o_valid(w_valid), .o_halted(w_halted),
      .o_epc(w_epc), .o_int_ack(w_int_ack)
   );
`endif

   function automatic step_t mk(int st, int ov, int hl, int it, int tg, int code,
                                int ev, int pc, int h, int epc, int ack);
      step_t s;
      s.st = 1'(st); s.ov = 1'(ov); s.hl = 1'(hl); s.it = 1'(it);
      s.tg = PW'(tg); s.code = 4'(code); s.ev = 1'(ev);
      s.pc = PW'(pc); s.halted = 1'(h); s.epc = PW'(epc); s.ack = 1'(ack);
      return s;
   endfunction

   task automatic drive(input step_t s);
      i_stall = s.st; i_pc_override = s.ov; i_halt = s.hl; i_interrupt = s.it;
      i_target = s.tg; i_int_code = s.code;
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      total++; if (o_pc !== PW'(0)) $display("FAIL reset_pc: got %h want 0", o_pc); else passed++;
      total++; if (o_halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", o_halted); else passed++;
      total++; if (o_epc !== PW'(0)) $display("FAIL reset_epc: got %h want 0", o_epc); else passed++;
      total++; if (o_int_ack !== 1'b0) $display("FAIL reset_ack: got %b want 0", o_int_ack); else passed++;
      @(negedge clk); rst = 1'b0; #1;
      total++; if (o_pc !== PW'(0)) $display("FAIL release_pc: got %h want 0", o_pc); else passed++;
      total++; if (o_valid !== 1'b1) $display("FAIL release_valid: got %b want 1", o_valid); else passed++;
   endtask

   task automatic test_sequential();
      step_t t[4] = '{mk(0,0,0,0,0,0,1,1,0,0,0), mk(0,0,0,0,0,0,1,2,0,0,0),
                      mk(0,0,0,0,0,0,1,3,0,0,0), mk(0,0,0,0,0,0,1,4,0,0,0)};
      exp_t e;
      foreach (t[i]) begin
         drive(t[i]); #1;
         total++; if (o_valid !== t[i].ev) $display("FAIL seq_valid[%0d]: got %b want %b", i, o_valid, t[i].ev); else passed++;
         sb.push_back('{t[i].pc, t[i].halted, t[i].epc, t[i].ack});
         @(posedge clk); #1; e = sb.pop_front();
         total++; if (o_pc !== e.pc) $display("FAIL seq_pc[%0d]: got %h want %h", i, o_pc, e.pc); else passed++;
         total++; if (o_halted !== e.halted) $display("FAIL seq_halted[%0d]: got %b want %b", i, o_halted, e.halted); else passed++;
         @(negedge clk);
      end
   endtask

   task automatic test_stall();
      step_t t[7] = '{mk(0,0,0,0,0,0,1,5,0,0,0), mk(1,0,0,0,0,0,0,5,0,0,0),
                      mk(1,0,0,0,0,0,0,5,0,0,0), mk(1,0,0,0,0,0,0,5,0,0,0),
                      mk(0,0,0,0,0,0,1,6,0,0,0), mk(0,0,0,0,0,0,1,7,0,0,0),
                      mk(0,0,0,0,0,0,1,8,0,0,0)};
      exp_t e;
      foreach (t[i]) begin
         drive(t[i]); #1;
         total++; if (o_valid !== t[i].ev) $display("FAIL stall_valid[%0d]: got %b want %b", i, o_valid, t[i].ev); else passed++;
         sb.push_back('{t[i].pc, t[i].halted, t[i].epc, t[i].ack});
         @(posedge clk); #1; e = sb.pop_front();
         total++; if (o_pc !== e.pc) $display("FAIL stall_pc[%0d]: got %h want %h", i, o_pc, e.pc); else passed++;
         @(negedge clk);
      end
   endtask

   task automatic test_override();
      step_t t[6] = '{mk(1,1,0,0,'h40,0,0,'h40,0,0,0), mk(0,1,0,0,'hFF,0,0,'hFF,0,0,0),
                      mk(0,0,0,0,0,0,1,'h00,0,0,0),      mk(0,1,0,0,'h0A,0,0,'h0A,0,0,0),
                      mk(0,0,0,0,0,0,1,'h0B,0,0,0),      mk(0,0,0,0,0,0,1,'h0C,0,0,0)};
      exp_t e;
      foreach (t[i]) begin
         drive(t[i]); #1;
         total++; if (o_valid !== t[i].ev) $display("FAIL ovr_valid[%0d]: got %b want %b", i, o_valid, t[i].ev); else passed++;
         sb.push_back('{t[i].pc, t[i].halted, t[i].epc, t[i].ack});
         @(posedge clk); #1; e = sb.pop_front();
         total++; if (o_pc !== e.pc) $display("FAIL ovr_pc[%0d]: got %h want %h", i, o_pc, e.pc); else passed++;
         total++; if (o_int_ack !== e.ack) $display("FAIL ovr_ack[%0d]: got %b want %b", i, o_int_ack, e.ack); else passed++;
         @(negedge clk);
      end
   endtask

   task automatic test_halt();
      step_t t[4] = '{mk(0,0,1,0,0,0,0,'h0C,1,0,0),    mk(0,1,0,0,'h40,0,0,'h0C,1,0,0),
                      mk(1,1,1,0,'h20,0,0,'h0C,1,0,0), mk(0,0,0,0,0,0,0,'h0C,1,0,0)};
      exp_t e;
      foreach (t[i]) begin
         drive(t[i]); #1;
         total++; if (o_valid !== t[i].ev) $display("FAIL halt_valid[%0d]: got %b want %b", i, o_valid, t[i].ev); else passed++;
         sb.push_back('{t[i].pc, t[i].halted, t[i].epc, t[i].ack});
         @(posedge clk); #1; e = sb.pop_front();
         total++; if (o_pc !== e.pc) $display("FAIL halt_pc[%0d]: got %h want %h", i, o_pc, e.pc); else passed++;
         total++; if (o_halted !== e.halted) $display("FAIL halt_state[%0d]: got %b want %b", i, o_halted, e.halted); else passed++;
         @(negedge clk);
      end
   endtask

`ifdef FETCH_INTERRUPT_EN
   task automatic test_interrupt();
      step_t t[4] = '{mk(0,0,0,1,0,3,0,'h13,0,'h0C,1), mk(0,0,0,0,0,0,1,'h14,0,'h0C,0),
                      mk(0,0,1,1,0,0,0,'h10,0,'h14,1), mk(0,0,0,0,0,0,1,'h11,0,'h14,0)};
      exp_t e;
      foreach (t[i]) begin
         drive(t[i]); #1;
         total++; if (o_valid !== t[i].ev) $display("FAIL int_valid[%0d]: got %b want %b", i, o_valid, t[i].ev); else passed++;
         sb.push_back('{t[i].pc, t[i].halted, t[i].epc, t[i].ack});
         @(posedge clk); #1; e = sb.pop_front();
         total++; if (o_pc !== e.pc) $display("FAIL int_pc[%0d]: got %h want %h", i, o_pc, e.pc); else passed++;
         total++; if (o_halted !== e.halted) $display("FAIL int_halted[%0d]: got %b want %b", i, o_halted, e.halted); else passed++;
         total++; if (o_epc !== e.epc) $display("FAIL int_epc[%0d]: got %h want %h", i, o_epc, e.epc); else passed++;
         total++; if (o_int_ack !== e.ack) $display("FAIL int_ack[%0d]: got %b want %b", i, o_int_ack, e.ack); else passed++;
         @(negedge clk);
      end
      // Vector base at all-ones minus one plus code 3 wraps to 1.
      w_interrupt = 1'b1; w_halt = 1'b1; w_int_code = 4'd3;
      sb.push_back('{PW'(1), 1'b0, '0, 1'b1});
      @(posedge clk); #1; e = sb.pop_front();
      total++; if (w_pc !== e.pc) $display("FAIL wrap_pc: got %h want %h", w_pc, e.pc); else passed++;
      total++; if (w_halted !== e.halted) $display("FAIL wrap_halted: got %b want %b", w_halted, e.halted); else passed++;
      total++; if (w_int_ack !== e.ack) $display("FAIL wrap_ack: got %b want %b", w_int_ack, e.ack); else passed++;
      @(negedge clk); w_interrupt = 1'b0; w_halt = 1'b0; w_int_code = '0;
      sb.push_back('{PW'(2), 1'b0, '0, 1'b0});
      @(posedge clk); #1; e = sb.pop_front();
      total++; if (w_pc !== e.pc) $display("FAIL wrap_next_pc: got %h want %h", w_pc, e.pc); else passed++;
      total++; if (w_int_ack !== e.ack) $display("FAIL wrap_ack_drop: got %b want %b", w_int_ack, e.ack); else passed++;
      @(negedge clk);
   endtask
`else
   task automatic test_interrupt();
      step_t t[2] = '{mk(0,0,0,1,0,3,0,'h0C,1,0,0), mk(0,0,0,1,0,9,0,'h0C,1,0,0)};
      exp_t e;
      foreach (t[i]) begin
         drive(t[i]); #1;
         total++; if (o_valid !== t[i].ev) $display("FAIL noint_valid[%0d]: got %b want %b", i, o_valid, t[i].ev); else passed++;
         sb.push_back('{t[i].pc, t[i].halted, t[i].epc, t[i].ack});
         @(posedge clk); #1; e = sb.pop_front();
         total++; if (o_pc !== e.pc) $display("FAIL noint_pc[%0d]: got %h want %h", i, o_pc, e.pc); else passed++;
         total++; if (o_halted !== e.halted) $display("FAIL noint_halted[%0d]: got %b want %b", i, o_halted, e.halted); else passed++;
         total++; if (o_epc !== e.epc) $display("FAIL noint_epc[%0d]: got %h want %h", i, o_epc, e.epc); else passed++;
         total++; if (o_int_ack !== e.ack) $display("FAIL noint_ack[%0d]: got %b want %b", i, o_int_ack, e.ack); else passed++;
         @(negedge clk);
      end
   endtask
`endif

   task automatic test_reset_mid();
      step_t t[2] = '{mk(0,0,0,0,0,0,1,1,0,0,0), mk(0,0,0,0,0,0,1,2,0,0,0)};
      exp_t e;
      drive(mk(0,1,1,0,'h40,0,0,0,0,0,0));
      @(posedge clk); #2;
      rst = 1'b1; #1;
      total++; if (o_pc !== PW'(0)) $display("FAIL async_rst_pc: got %h want 0", o_pc); else passed++;
      total++; if (o_halted !== 1'b0) $display("FAIL async_rst_halted: got %b want 0", o_halted); else passed++;
      total++; if (o_epc !== PW'(0)) $display("FAIL async_rst_epc: got %h want 0", o_epc); else passed++;
      @(negedge clk); rst = 1'b0;
      foreach (t[i]) begin
         drive(t[i]); #1;
         total++; if (o_valid !== t[i].ev) $display("FAIL rst_valid[%0d]: got %b want %b", i, o_valid, t[i].ev); else passed++;
         sb.push_back('{t[i].pc, t[i].halted, t[i].epc, t[i].ack});
         @(posedge clk); #1; e = sb.pop_front();
         total++; if (o_pc !== e.pc) $display("FAIL rst_resume_pc[%0d]: got %h want %h", i, o_pc, e.pc); else passed++;
         total++; if (o_halted !== e.halted) $display("FAIL rst_resume_halted[%0d]: got %b want %b", i, o_halted, e.halted); else passed++;
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_override();
      test_halt();
      test_interrupt();
      test_reset_mid();
      total++; if (sb.size() != 0) $display("FAIL sb_drain: got %0d entries want 0", sb.size()); else passed++;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got no finish want finish before 20000");
      $fatal(1);
   end

endmodule
